// File: rtl/cpu_debug_dumper.sv
// cpu_debug_dumper: steps the pipeline CPU on request, scans every GPR and the
// five stage PC/IR pairs through the debug select port, and streams one
// 170-byte frame (A5, 32 x 4 register bytes, 5 x 8 stage bytes, 5A) out of an
// 8N1 UART transmitter.
`timescale 1ns/1ps

module cpu_debug_dumper #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  HDR_BYTE     = 8'hA5,
    parameter logic [7:0]  TRL_BYTE     = 8'h5A
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        step_req,
    input  logic        dump_req,
    input  logic [31:0] chip_debug_out0,
    input  logic [31:0] chip_debug_out1,
    input  logic [31:0] chip_debug_out2,
    output logic        step,
    output logic [31:0] chip_debug_in,
    output logic        uart_tx,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, STEP, HDR, SEL, CAP, SEND, NEXT, TRL, DONE
    } state_t;

    localparam logic [15:0] BAUD_MAX  = 16'(CLKS_PER_BIT - 1);
    localparam logic [5:0]  LAST_ITEM = 6'd36;

    state_t      state;
    logic [5:0]  item;       // 0..31 GPRs, 32..36 stages IF..WB
    logic [63:0] payload;    // captured bytes, next byte to send in [63:56]
    logic [3:0]  byte_cnt;   // payload bytes not yet handed to the transmitter

    logic        tx_active;
    logic [3:0]  bit_cnt;    // 0 start, 1..8 data, 9 stop
    logic [15:0] baud_cnt;
    logic [7:0]  tx_shift;

    logic        baud_last;
    logic        byte_done;
    logic        tx_load;
    logic [7:0]  tx_byte;

    // Debug select for an item: GPR index in [4:0], stage index in [7:5].
    // For items 32..36 the low three bits of k already equal k-32.
    function automatic logic [31:0] item_sel(input logic [5:0] k);
        if (k < 6'd32)
            return {27'b0, k[4:0]};
        else
            return {24'b0, k[2:0], 5'b0};
    endfunction

    // Transmitter timing flags and the byte-load request from the FSM states.
    always_comb begin
        baud_last = (baud_cnt == BAUD_MAX);
        byte_done = tx_active && baud_last && (bit_cnt == 4'd9);
        tx_load   = 1'b0;
        tx_byte   = 8'h00;
        case (state)
            HDR: begin
                tx_load = !tx_active;
                tx_byte = HDR_BYTE;
            end
            TRL: begin
                tx_load = !tx_active;
                tx_byte = TRL_BYTE;
            end
            SEND: begin
                // Back-to-back bytes: reload in the same cycle the stop bit ends.
                tx_load = !tx_active || (byte_done && byte_cnt != 4'd0);
                tx_byte = payload[63:56];
            end
            default: ;
        endcase
    end

    // Sequencer: request handling, step pulse, debug select, payload capture.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only; aresetn is not in the sensitivity list.
        if (!aresetn) begin
            state         <= IDLE;
            item          <= '0;
            byte_cnt      <= '0;
            step          <= 1'b0;
            busy          <= 1'b0;
            chip_debug_in <= '0;
            // NOTE: payload is plain data, always overwritten in CAP before use, so it
            // is reset only for deterministic simulation; nothing depends on it.
            payload       <= '0;
        end else begin
            // NOTE: all sequential state uses <= so every branch sees pre-edge values.
            step <= 1'b0;
            case (state)
                IDLE: begin
                    if (step_req) begin
                        state <= STEP;
                        busy  <= 1'b1;
                        step  <= 1'b1;
                    end else if (dump_req) begin
                        state <= HDR;
                        busy  <= 1'b1;
                    end
                end
                STEP: state <= HDR;
                HDR: begin
                    if (byte_done) begin
                        item          <= '0;
                        chip_debug_in <= item_sel(6'd0);
                        state         <= SEL;
                    end
                end
                SEL: state <= CAP;
                CAP: begin
                    if (item < 6'd32) begin
                        payload  <= {chip_debug_out0, 32'h0};
                        byte_cnt <= 4'd4;
                    end else begin
                        payload  <= {chip_debug_out1, chip_debug_out2};
                        byte_cnt <= 4'd8;
                    end
                    state <= SEND;
                end
                SEND: begin
                    if (tx_load) begin
                        payload  <= payload << 8;
                        byte_cnt <= byte_cnt - 4'd1;
                    end else if (byte_done && byte_cnt == 4'd0) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (item == LAST_ITEM) begin
                        state <= TRL;
                    end else begin
                        item          <= item + 6'd1;
                        chip_debug_in <= item_sel(item + 6'd1);
                        state         <= SEL;
                    end
                end
                TRL: if (byte_done) state <= DONE;
                DONE: begin
                    chip_debug_in <= '0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // 8N1 transmitter: start bit, eight data bits LSB first, stop bit.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            tx_active <= 1'b0;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            tx_shift  <= '0;
            uart_tx   <= 1'b1;
        end else if (tx_load) begin
            tx_active <= 1'b1;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            tx_shift  <= tx_byte;
            uart_tx   <= 1'b0;
        end else if (tx_active) begin
            if (baud_last) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    tx_active <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd8) begin
                        uart_tx <= 1'b1;
                    end else begin
                        uart_tx  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end
                end
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_debug_dumper.sv
// Directed bench for cpu_debug_dumper: stub CPU debug buses, UART frame decoder,
// step pulse counter, and a byte model of the expected 170-byte frame.
`timescale 1ns/1ps

module tb_cpu_debug_dumper;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        step_req = 1'b0;
    logic        dump_req = 1'b0;
    logic [31:0] chip_debug_out0, chip_debug_out1, chip_debug_out2;
    logic        step;
    logic [31:0] chip_debug_in;
    logic        uart_tx;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int step_cnt = 0;
    int hi_viol = 0;
    int framing_err = 0;
    int last_push_cyc = 0;
    int s0;
    int n;

    byte unsigned rx_q[$];
    logic        dec_on = 1'b0;
    int          dec_cnt = 0;
    logic [7:0]  dec_sr = 8'h00;

    logic [7:0] ex_exp [8] = '{8'h00, 8'h00, 8'h02, 8'h00, 8'hDE, 8'hAD, 8'h00, 8'h02};
    logic [7:0] if_exp [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'h00, 8'h00};
    logic [7:0] r3_exp [4] = '{8'h10, 8'h00, 8'h00, 8'h03};

    always #5 clk = ~clk;

    cpu_debug_dumper #(.CLKS_PER_BIT(CPB)) dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .step_req        (step_req),
        .dump_req        (dump_req),
        .chip_debug_out0 (chip_debug_out0),
        .chip_debug_out1 (chip_debug_out1),
        .chip_debug_out2 (chip_debug_out2),
        .step            (step),
        .chip_debug_in   (chip_debug_in),
        .uart_tx         (uart_tx),
        .busy            (busy)
    );

    // CPU debug stub
    always_comb begin
        chip_debug_out0 = 32'h1000_0000 + {27'b0, chip_debug_in[4:0]};
        chip_debug_out1 = {21'b0, chip_debug_in[7:5], 8'h00};
        chip_debug_out2 = 32'hDEAD_0000 | {29'b0, chip_debug_in[7:5]};
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitors sampled on the falling edge
    always @(negedge clk) begin
        if (step === 1'b1) step_cnt <= step_cnt + 1;
        if (chip_debug_in[31:8] !== 24'h0) hi_viol <= hi_viol + 1;
    end

    // UART 8N1 decoder, samples mid-bit (offset 2 of 4 clocks)
    always @(negedge clk) begin
        if (!aresetn) begin
            dec_on <= 1'b0;
        end else if (!dec_on) begin
            if (uart_tx === 1'b0) begin
                dec_on  <= 1'b1;
                dec_cnt <= 1;
            end
        end else begin
            dec_cnt <= dec_cnt + 1;
            if (dec_cnt == 2) begin
                if (uart_tx !== 1'b0) framing_err <= framing_err + 1;
            end else if (dec_cnt >= 6 && dec_cnt <= 34 && (dec_cnt % 4) == 2) begin
                dec_sr <= {uart_tx, dec_sr[7:1]};
            end else if (dec_cnt == 38) begin
                if (uart_tx !== 1'b1) framing_err <= framing_err + 1;
                rx_q.push_back(dec_sr);
                last_push_cyc <= cyc;
                dec_on <= 1'b0;
            end
        end
    end

    function automatic logic [7:0] exp_byte(input int idx);
        int m;
        logic [31:0] w;
        logic [63:0] d;
        if (idx == 0) return 8'hA5;
        if (idx == 169) return 8'h5A;
        if (idx <= 128) begin
            m = idx - 1;
            w = 32'h1000_0000 + 32'(m / 4);
            return 8'(w >> (8 * (3 - m % 4)));
        end
        m = idx - 129;
        d = {32'(m / 8) << 8, 32'hDEAD_0000 | 32'(m / 8)};
        return 8'(d >> (8 * (7 - m % 8)));
    endfunction

    function automatic logic [7:0] rx_at(input int idx);
        if (idx < rx_q.size()) return rx_q[idx];
        return 8'hxx;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_not_busy(input string tag, input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_busy_fall"}, busy, 1'b0);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_len"}, rx_q.size(), 170);
        for (int i = 0; i < 170; i++)
            check($sformatf("%s_b%0d", tag, i), rx_at(i), exp_byte(i));
    endtask

    initial begin
        // Reset held for 5 cycles
        aresetn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_out", {uart_tx, step, busy, chip_debug_in}, {1'b1, 1'b0, 1'b0, 32'h0});
        end
        aresetn = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            check("idle_out", {uart_tx, step, busy, chip_debug_in}, {1'b1, 1'b0, 1'b0, 32'h0});
        end

        // Single step
        rx_q.delete();
        s0 = step_cnt;
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        check("step_hi", step, 1'b1);
        check("busy_hi", busy, 1'b1);
        @(negedge clk);
        check("step_lo", step, 1'b0);
        wait_not_busy("step", 20000);
        check("busy_after_stop", (cyc - last_push_cyc) >= 2, 1'b1);
        check("step_count", step_cnt - s0, 1);
        check("line_idle", uart_tx, 1'b1);
        check("sel_idle", chip_debug_in, 32'h0);
        check_frame("step");
        for (int i = 0; i < 4; i++) check($sformatf("reg3_%0d", i), rx_at(13 + i), r3_exp[i]);
        for (int i = 0; i < 8; i++) check($sformatf("ex_%0d", i), rx_at(145 + i), ex_exp[i]);
        for (int i = 0; i < 8; i++) check($sformatf("if_%0d", i), rx_at(129 + i), if_exp[i]);
        check("sel_hi_zero", hi_viol, 0);

        // Dump only
        rx_q.delete();
        s0 = step_cnt;
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        check("dump_step_lo", step, 1'b0);
        check("dump_busy_hi", busy, 1'b1);
        wait_not_busy("dump", 20000);
        check("dump_step_count", step_cnt - s0, 0);
        check_frame("dump");

        // Requests during a frame are dropped
        rx_q.delete();
        s0 = step_cnt;
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        n = 0;
        while (rx_q.size() < 41 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("reach_reg10", rx_q.size() >= 41, 1'b1);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        @(negedge clk);
        check("mid_step_lo", step, 1'b0);
        repeat (20) @(negedge clk);
        dump_req = 1'b1;
        step_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        step_req = 1'b0;
        wait_not_busy("mid", 20000);
        check("mid_step_count", step_cnt - s0, 0);
        check_frame("mid");
        repeat (200) @(negedge clk);
        check("no_requeue_busy", busy, 1'b0);
        check("no_requeue_len", rx_q.size(), 170);

        // Simultaneous step_req + dump_req while idle
        rx_q.delete();
        s0 = step_cnt;
        step_req = 1'b1;
        dump_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        dump_req = 1'b0;
        check("both_step_hi", step, 1'b1);
        wait_not_busy("both", 20000);
        check("both_step_count", step_cnt - s0, 1);
        check_frame("both");

        // Reset in the middle of frame byte 50
        rx_q.delete();
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        n = 0;
        while (rx_q.size() < 50 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("reach_b50", rx_q.size() >= 50, 1'b1);
        repeat (15) @(negedge clk);
        check("b50_data_low", uart_tx, 1'b0);
        aresetn = 1'b0;
        @(negedge clk);
        check("abort_out", {uart_tx, step, busy, chip_debug_in}, {1'b1, 1'b0, 1'b0, 32'h0});
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        rx_q.delete();
        check("post_rst_idle", {uart_tx, busy}, {1'b1, 1'b0});
        s0 = step_cnt;
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        check("rst_step_hi", step, 1'b1);
        wait_not_busy("after_rst", 20000);
        check("rst_step_count", step_cnt - s0, 1);
        check_frame("after_rst");

        check("framing", framing_err, 0);
        check("sel_hi_zero_end", hi_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_debug_dumper.md
Name: cpu_debug_dumper

Overview:
- Host-side partner of the pipeline CPU's single-step/debug interface.
- Generates the CPU `step` pulse and drives `chip_debug_in` to scan all 32 GPRs and the five stage PC/IR pairs (IF, ID, EX, ME, WB).
- Captures `chip_debug_out0/1/2` and streams a fixed-format frame out over a UART 8N1 transmitter, so a PC can trace the pipeline one step at a time.
- Sits at board top level between the debounced buttons, the CPU and the USB-UART pin.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit; legal range 2..65535.
- HDR_BYTE, 8'hA5, frame header byte.
- TRL_BYTE, 8'h5A, frame trailer byte.

Ports:
- clk  in  1  system clock
- aresetn  in  1  reset
- step_req  in  1  one-cycle pulse: advance CPU one step, then dump
- dump_req  in  1  one-cycle pulse: dump only, no step
- chip_debug_out0  in  32  GPR value selected by chip_debug_in[4:0]
- chip_debug_out1  in  32  stage PC selected by chip_debug_in[7:5]
- chip_debug_out2  in  32  stage IR selected by chip_debug_in[7:5] (0 for IF)
- step  out  1  CPU step enable, exactly one cycle per step_req
- chip_debug_in  out  32  debug select; bits [31:8] always 0
- uart_tx  out  1  serial data, idle high
- busy  out  1  high from request acceptance until trailer stop bit completes

Behaviour:
- Reset: reset aresetn, synchronous, active-low; clock clk. While aresetn=0 on a clk edge:
  - step=0, chip_debug_in=0, uart_tx=1, busy=0.
  - FSM forced to IDLE; all counters cleared.
  - Reset mid-frame aborts the frame immediately. No partial byte completes; the line goes high on the next edge.
- All outputs are registered.
- FSM states: IDLE, STEP, HDR, SEL, CAP, SEND, NEXT, TRL, DONE.
- IDLE: busy=0.
  - step_req=1 -> STEP, busy=1.
  - Else dump_req=1 -> HDR, busy=1.
  - step_req takes priority if both are high in the same cycle.
- STEP: step=1 for exactly this one cycle -> HDR.
- HDR: load HDR_BYTE into the transmitter -> SEL once the byte is fully sent.
- Dump order: item index k=0..36.
  - k<32: chip_debug_in = {24'b0, 3'b0, k[4:0]}; payload = out0, 4 bytes.
  - k>=32: s=k-32; chip_debug_in = {24'b0, s[2:0], 5'b0}; payload = out1 then out2, 8 bytes.
  - Items 32..36 correspond to stages IF, ID, EX, ME, WB in that order.
- SEL: drive chip_debug_in for k; hold one settle cycle -> CAP.
- CAP: latch the payload into a 64-bit shift buffer; set byte count to 4 or 8 -> SEND.
  - The captured value is the one present in the CAP cycle.
  - Later changes on the out buses are ignored until the next CAP.
- SEND: transmit payload bytes most-significant first (big-endian words; PC before IR).
  - After the last byte -> NEXT.
- NEXT: k==36 -> TRL; else k++ -> SEL.
- TRL: transmit TRL_BYTE -> DONE.
- DONE: chip_debug_in=0, busy=0 -> IDLE.
- Frame layout: 1 header byte + 128 register bytes + 40 stage bytes + 1 trailer byte = 170 bytes.
- UART TX (8N1):
  - Start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly CLKS_PER_BIT cycles.
  - Next byte's start bit begins the cycle after the previous stop bit ends, except across SEL/CAP gaps, where uart_tx stays 1.
  - Bit counter is 4-bit; baud counter is 16-bit and wraps to 0 at CLKS_PER_BIT-1.
- Requests while busy=1 (step_req or dump_req) are dropped, not queued; step stays 0.
- step is never asserted outside STEP, including during or immediately after reset.

Test Plan:
- Reset check: hold aresetn=0 for 5 cycles -> uart_tx=1, step=0, busy=0, chip_debug_in=0 on every cycle; after release with no requests, outputs remain unchanged for 1000 cycles.
- Single step with CLKS_PER_BIT=4 and stub out0=32'h1000_0000+sel[4:0] -> step high exactly one cycle (the cycle after step_req); decoded frame is 170 bytes, first A5, last 5A; bytes 13..16 (reg 3) are 10 00 00 03; busy falls after the final stop bit.
- Stage scan: stub out1=32'h0000_0100*sel[7:5], out2=32'hDEAD_0000|sel[7:5] -> EX item (stage 2) bytes are 00 00 02 00 DE AD 00 02; IF item is 00 00 00 00 DE AD 00 00; chip_debug_in[31:8]==0 throughout.
- dump_req only -> step never asserts; frame identical in format to the step case.
- step_req and dump_req pulsed at register index 10, plus simultaneous step_req+dump_req while IDLE -> mid-frame pulses are ignored (no step, frame byte count stays 170); the simultaneous pulse produces exactly one step.
- Reset asserted mid-byte at frame byte 50, then step_req -> uart_tx=1 on the edge after reset; the new frame starts with A5 and a complete 170-byte frame.
